// File: rtl/mux21_2bits_rr_stage.sv
// Two buffered 2-bit input streams merged by a round-robin arbiter into a
// registered valid/ready output that feeds the 2-bit output flop stage.

module mux21_2bits_rr_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              not_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                wptr, rptr;
    logic [CW-1:0]                count;
    logic                         push;

    // Ready depends on the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready  = count < FULL;
    assign push      = in_valid && in_ready;
    assign head      = mem[rptr];
    assign not_empty = count != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wptr] <= in_data;
    end
endmodule

module mux21_2bits_rr_stage #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel
);
    logic [1:0]             ch_valid, ch_ready, ch_pop, ch_ne;
    logic [1:0][DATA_W-1:0] ch_data, ch_head;
    logic                   last_grant, load, any, winner;

    assign ch_valid  = {in1_valid, in0_valid};
    assign ch_data   = {in1_data, in0_data};
    assign in0_ready = ch_ready[0];
    assign in1_ready = ch_ready[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        mux21_2bits_rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (ch_valid[c]),
            .in_data   (ch_data[c]),
            .in_ready  (ch_ready[c]),
            .pop       (ch_pop[c]),
            .head      (ch_head[c]),
            .not_empty (ch_ne[c])
        );
    end

    // Under contention the channel that did not win last time is granted.
    always_comb begin
        load   = !out_valid || out_ready;
        any    = |ch_ne;
        winner = (&ch_ne) ? ~last_grant : ch_ne[1];
        ch_pop = '0;
        if (load && any) ch_pop[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 1'b0;
            last_grant <= 1'b1;
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_data   <= ch_head[winner];
                out_sel    <= winner;
                last_grant <= winner;
            end
        end
    end
endmodule
